// File: rtl/mic_detector.sv
// mic_detector: synchronizes and debounces a raw microphone output, qualifies
// sounds that persist long enough, then ignores the input for a cooldown
// window after each sound ends. sound_evt/sound_active are registered.
// Optional feature: define MIC_DETECTOR_EVT_COUNT_EN to build the saturating
// evt_count register with its evt_clr clear; otherwise evt_count is 8'd0.
module mic_detector #(
  parameter int unsigned DEBOUNCE_CYCLES   = 50000,
  parameter int unsigned MIN_ACTIVE_CYCLES = 1000000,
  parameter int unsigned COOLDOWN_CYCLES   = 25000000,
  parameter logic        ACTIVE_LEVEL      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mic,
  input  logic       enable,
  input  logic       evt_clr,
  output logic       sound_evt,
  output logic       sound_active,
  output logic [7:0] evt_count
);

  localparam int unsigned MAX_CYC = (MIN_ACTIVE_CYCLES > COOLDOWN_CYCLES) ?
                                    MIN_ACTIVE_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 32'd1);
  localparam logic [TW-1:0] MIN_LAST  = TW'(MIN_ACTIVE_CYCLES - 32'd1);
  localparam logic [TW-1:0] COOL_LAST = TW'(COOLDOWN_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUALIFY  = 2'd1,
    ACTIVE   = 2'd2,
    COOLDOWN = 2'd3
  } state_e;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          s_q, s_d;
  logic          deb_q, deb_d;
  logic [DW-1:0] deb_cnt_q, deb_cnt_d;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          sound_evt_q, sound_evt_d;
  logic          sound_active_q, sound_active_d;

  // Synchronizer shift, registered "sound present" compare and debounce rule.
  always_comb begin
    sync1_d   = mic;
    sync2_d   = sync1_q;
    s_d       = (sync2_q == ACTIVE_LEVEL);
    deb_d     = deb_q;
    deb_cnt_d = deb_cnt_q;
    if (s_q == deb_q) begin
      deb_cnt_d = {DW{1'b0}};
    end else if (deb_cnt_q == DEB_LAST) begin
      deb_d     = s_q;
      deb_cnt_d = {DW{1'b0}};
    end else begin
      deb_cnt_d = deb_cnt_q + DW'(1);
    end
  end

  // Front-end registers; the synchronizer idles at the "no sound" level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= ~ACTIVE_LEVEL;
      sync2_q   <= ~ACTIVE_LEVEL;
      s_q       <= 1'b0;
      deb_q     <= 1'b0;
      deb_cnt_q <= {DW{1'b0}};
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      s_q       <= s_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  // Detection FSM next state, shared timer and registered output values.
  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    sound_evt_d    = 1'b0;
    sound_active_d = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      timer_d = {TW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          timer_d = {TW{1'b0}};
          if (deb_q) begin
            state_d = QUALIFY;
          end else begin
            state_d = IDLE;
          end
        end
        QUALIFY: begin
          if (!deb_q) begin
            // Sound ended before it qualified: drop it silently.
            state_d = IDLE;
            timer_d = {TW{1'b0}};
          end else if (timer_q == MIN_LAST) begin
            state_d     = ACTIVE;
            timer_d     = {TW{1'b0}};
            sound_evt_d = 1'b1;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ACTIVE: begin
          if (!deb_q) begin
            state_d = COOLDOWN;
            timer_d = {TW{1'b0}};
          end else begin
            state_d = ACTIVE;
          end
        end
        COOLDOWN: begin
          // deb is deliberately ignored here.
          if (timer_q == COOL_LAST) begin
            state_d = IDLE;
            timer_d = {TW{1'b0}};
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          timer_d = {TW{1'b0}};
        end
      endcase
    end
    sound_active_d = (state_d == ACTIVE);
  end

  // FSM state, timer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      timer_q        <= {TW{1'b0}};
      sound_evt_q    <= 1'b0;
      sound_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      sound_evt_q    <= sound_evt_d;
      sound_active_q <= sound_active_d;
    end
  end

  assign sound_evt    = sound_evt_q;
  assign sound_active = sound_active_q;

`ifdef MIC_DETECTOR_EVT_COUNT_EN
  logic [7:0] evt_count_q, evt_count_d;

  // Saturating event count; a clear coinciding with an event leaves 1.
  always_comb begin
    evt_count_d = evt_count_q;
    if (evt_clr) begin
      evt_count_d = sound_evt_q ? 8'd1 : 8'd0;
    end else if (sound_evt_q && (evt_count_q != 8'd255)) begin
      evt_count_d = evt_count_q + 8'd1;
    end else begin
      evt_count_d = evt_count_q;
    end
  end

  // Event counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_count_q <= 8'd0;
    end else begin
      evt_count_q <= evt_count_d;
    end
  end

  assign evt_count = evt_count_q;
`else
  logic unused_evt_clr_s;
  assign unused_evt_clr_s = evt_clr;
  assign evt_count        = 8'd0;
`endif

endmodule

// File: tb/tb_mic_detector.sv
// Testbench for mic_detector (DEBOUNCE=4, MIN_ACTIVE=8, COOLDOWN=16,
// ACTIVE_LEVEL=1). Outputs are checked every cycle against a timestamp-based
// reference model, plus directed checks on latency, rejection, cooldown,
// enable/reset aborts and counter saturation/clear.
module tb_mic_detector;

  localparam int DEB  = 4;
  localparam int MINA = 8;
  localparam int COOL = 16;
  localparam int LOGN = 32768;
`ifdef MIC_DETECTOR_EVT_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, mic, enable, evt_clr;
  logic       sound_evt, sound_active;
  logic [7:0] evt_count;

  mic_detector #(
    .DEBOUNCE_CYCLES  (DEB),
    .MIN_ACTIVE_CYCLES(MINA),
    .COOLDOWN_CYCLES  (COOL),
    .ACTIVE_LEVEL     (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .mic         (mic),
    .enable      (enable),
    .evt_clr     (evt_clr),
    .sound_evt   (sound_evt),
    .sound_active(sound_active),
    .evt_count   (evt_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int edge_no = 0;
  int n_evt = 0;
  int n_act = 0;
  int last_evt_edge = 0;

  // Reference model: raw mic history plus phase/timestamp bookkeeping.
  bit mic_log [0:LOGN-1];
  int rst_edge = 0;
  bit m_deb = 1'b0;
  int m_phase = 0;   // 0 idle, 1 qualifying, 2 sounding, 3 cooling down
  int m_t0 = 0;
  bit m_evt = 1'b0;
  bit m_act = 1'b0;
  int m_cnt = 0;

  // "Sound present" as seen by the detector just before edge e: the mic
  // sampled three edges earlier, or idle if that sample predates reset.
  function automatic bit s_before(int e);
    int k;
    k = e - 3;
    if (k < 0 || k <= rst_edge || k >= LOGN) return 1'b0;
    return mic_log[k];
  endfunction

  task automatic model_update();
    int  e;
    bit  deb_pre, evt_prev, flip;
    e = edge_no;
    if (e < LOGN) mic_log[e] = (mic === 1'b1);
    if (rst) begin
      rst_edge = e; m_deb = 1'b0; m_phase = 0; m_t0 = 0;
      m_evt = 1'b0; m_act = 1'b0; m_cnt = 0;
    end else begin
      deb_pre  = m_deb;
      evt_prev = m_evt;
      // Level flips once DEB consecutive samples disagree with it.
      flip = 1'b1;
      for (int i = 0; i < DEB; i++) begin
        if (s_before(e - i) == deb_pre) flip = 1'b0;
      end
      if (flip) m_deb = ~deb_pre;
      m_evt = 1'b0;
      if (!enable) begin
        m_phase = 0;
      end else begin
        case (m_phase)
          0: if (deb_pre) begin m_phase = 1; m_t0 = e; end
          1: if (!deb_pre) m_phase = 0;
             else if (e - m_t0 == MINA) begin m_phase = 2; m_evt = 1'b1; end
          2: if (!deb_pre) begin m_phase = 3; m_t0 = e; end
          3: if (e - m_t0 == COOL) m_phase = 0;
          default: m_phase = 0;
        endcase
      end
      m_act = (m_phase == 2);
      if (CNT_EN) begin
        if (evt_clr) m_cnt = evt_prev ? 1 : 0;
        else if (evt_prev && m_cnt < 255) m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: model the edge, then sample outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    edge_no++;
    model_update();
    #1;
    chk("sound_evt", 32'(sound_evt), 32'(m_evt));
    chk("sound_active", 32'(sound_active), 32'(m_act));
    chk("evt_count", 32'(evt_count), 32'(m_cnt));
    if (sound_evt === 1'b1) begin n_evt++; last_evt_edge = edge_no; end
    if (sound_active === 1'b1) n_act++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int e0, e1, cnt_before;
    bit found;
    rst = 1'b1; mic = 1'b0; enable = 1'b1; evt_clr = 1'b0;
    run(3);
    chk("reset_evt", 32'(sound_evt), 32'd0);
    chk("reset_active", 32'(sound_active), 32'd0);
    chk("reset_count", 32'(evt_count), 32'd0);
    rst = 1'b0;
    run(5);

    // Steady 40-cycle sound: one event, 15 edges after the first sample.
    n_evt = 0; e0 = edge_no + 1;
    mic = 1'b1; run(40);
    mic = 1'b0; run(40);
    chk("single_evt", n_evt, 32'd1);
    chk("evt_latency", last_evt_edge - e0, 32'd15);
    chk("count_one", 32'(evt_count), CNT_EN ? 32'd1 : 32'd0);

    // Bounce: 3 on / 3 off never survives the debouncer.
    n_evt = 0; n_act = 0;
    for (int r = 0; r < 10; r++) begin
      mic = 1'b1; run(3);
      mic = 1'b0; run(3);
    end
    run(20);
    chk("bounce_no_evt", n_evt, 32'd0);
    chk("bounce_no_active", n_act, 32'd0);

    // 8 high cycles clear debounce but not qualification; 9 just qualify.
    n_evt = 0;
    mic = 1'b1; run(8);
    mic = 1'b0; run(40);
    chk("short_rejected", n_evt, 32'd0);
    chk("short_count", 32'(evt_count), CNT_EN ? 32'd1 : 32'd0);
    n_evt = 0;
    mic = 1'b1; run(9);
    mic = 1'b0; run(40);
    chk("min_qualifies", n_evt, 32'd1);

    // Second sound 5 cycles after the first is held off by cooldown.
    n_evt = 0;
    mic = 1'b1; run(40);
    mic = 1'b0; run(5);
    e1 = edge_no + 1;
    mic = 1'b1; run(40);
    mic = 1'b0; run(40);
    chk("cooldown_two_evts", n_evt, 32'd2);
    chk("cooldown_delay", last_evt_edge - e1, 32'd27);
    chk("count_four", 32'(evt_count), CNT_EN ? 32'd4 : 32'd0);

    // Enable dropped while sounding.
    mic = 1'b1; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (sound_active === 1'b1) found = 1'b1;
    end
    chk("reach_active", 32'(found), 32'd1);
    enable = 1'b0; step();
    chk("en_drop_active", 32'(sound_active), 32'd0);
    chk("en_drop_evt", 32'(sound_evt), 32'd0);
    enable = 1'b1; mic = 1'b0; run(60);

    // Reset while qualifying aborts without an event.
    n_evt = 0;
    mic = 1'b1; run(10);
    rst = 1'b1; mic = 1'b0; step();
    chk("rst_q_active", 32'(sound_active), 32'd0);
    chk("rst_q_evt", 32'(sound_evt), 32'd0);
    rst = 1'b0; run(40);
    chk("rst_abort_no_evt", n_evt, 32'd0);

    // Saturation after 260 qualified sounds.
    for (int k = 0; k < 260; k++) begin
      mic = 1'b1; run(20);
      mic = 1'b0; run(30);
    end
    chk("saturate", 32'(evt_count), CNT_EN ? 32'd255 : 32'd0);

    // Clear landing on the same cycle as an event leaves exactly 1.
    mic = 1'b1; found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (sound_evt === 1'b1) found = 1'b1;
    end
    chk("reach_evt", 32'(found), 32'd1);
    evt_clr = 1'b1; step(); evt_clr = 1'b0;
    chk("clr_with_evt", 32'(evt_count), CNT_EN ? 32'd1 : 32'd0);
    mic = 1'b0; run(40);
    evt_clr = 1'b1; step(); evt_clr = 1'b0;
    chk("clr_plain", 32'(evt_count), 32'd0);
    cnt_before = nmis;

    // Randomized segments checked cycle by cycle against the model.
    for (int seg = 0; seg < 80; seg++) begin
      mic     = 1'($urandom_range(0, 1));
      enable  = ($urandom_range(0, 19) != 0);
      evt_clr = ($urandom_range(0, 9) == 0);
      rst     = ($urandom_range(0, 49) == 0);
      run($urandom_range(1, 30));
    end
    rst = 1'b0; enable = 1'b1; evt_clr = 1'b0; mic = 1'b0;
    run(60);
    if (nmis != cnt_before) $display("random phase added %0d miscompares", nmis - cnt_before);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
